// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned LineBits       = 256;
  localparam int unsigned BurstBits      = 64;
  localparam int unsigned BeatsPerLine   = LineBits / BurstBits;
  localparam int unsigned LineOffsetBits = 5;

  typedef logic [LineBits-1:0]  line_t;
  typedef logic [BurstBits-1:0] burst_t;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits 256-bit cache line reads/writes into 4-beat 64-bit memory bursts and
// reassembles fill lines, answering the cache with a single resp pulse.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned LineW   = LineBits,
  parameter int unsigned BurstW  = BurstBits,
  parameter int unsigned AddrW   = 32,
  parameter int unsigned OffsetW = LineOffsetBits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LineW-1:0]  line_i,
  output logic [LineW-1:0]  line_o,
  input  logic [AddrW-1:0]  address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BurstW-1:0] burst_i,
  output logic [BurstW-1:0] burst_o,
  output logic [AddrW-1:0]  address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int unsigned Beats  = LineW / BurstW;
  localparam int unsigned CountW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CountW-1:0] LastBeat   = CountW'(Beats - 1);
  localparam logic [AddrW-1:0]  OffsetMask = AddrW'((64'd1 << OffsetW) - 64'd1);

  adaptor_state_t    state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [LineW-1:0]  wline_q, wline_d;
  logic [LineW-1:0]  rline_q, rline_d;
  logic [LineW-1:0]  line_q, line_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    line_d  = line_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (write_i) begin
          wline_d = line_i;
          addr_d  = address_i & ~OffsetMask;
          count_d = '0;
          state_d = StWr;
        end else if (read_i) begin
          addr_d  = address_i & ~OffsetMask;
          count_d = '0;
          state_d = StRd;
        end
      end
      StRd: begin
        read_o = 1'b1;
        if (resp_i) begin
          rline_d[BurstW*count_q +: BurstW] = burst_i;
          count_d = count_q + 1'b1;
          // Publish the line only once complete so line_o never shows a partial fill.
          if (count_q == LastBeat) begin
            line_d  = rline_d;
            state_d = StDone;
          end
        end
      end
      StWr: begin
        write_o = 1'b1;
        if (resp_i) begin
          count_d = count_q + 1'b1;
          if (count_q == LastBeat) state_d = StDone;
        end
      end
      StDone: begin
        resp_o  = 1'b1;
        count_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    burst_o = '0;
    if (state_q == StWr) burst_o = wline_q[BurstW*count_q +: BurstW];
  end

  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks   = 0;
  int failures = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: kind 0 = none, 1 = line read, 2 = line write.
  int           m_kind;
  int           m_beats;
  bit           m_done;
  logic [31:0]  m_addr;
  logic [63:0]  m_wbeat[4];
  logic [63:0]  m_rbeat[4];
  logic [255:0] m_line;

  task automatic model_reset();
    m_kind  = 0;
    m_beats = 0;
    m_done  = 0;
    m_addr  = '0;
    m_line  = '0;
    for (int k = 0; k < 4; k++) begin
      m_wbeat[k] = '0;
      m_rbeat[k] = '0;
    end
  endtask

  task automatic model_step();
    if (m_done) begin
      m_done = 0;
    end else if (m_kind == 0) begin
      if (write_i || read_i) begin
        m_kind  = write_i ? 2 : 1;
        m_addr  = {address_i[31:5], 5'b0};
        m_beats = 0;
        for (int k = 0; k < 4; k++) m_wbeat[k] = line_i[64*k +: 64];
      end
    end else if (resp_i) begin
      if (m_kind == 1) m_rbeat[m_beats] = burst_i;
      m_beats++;
      if (m_beats == 4) begin
        if (m_kind == 1) m_line = {m_rbeat[3], m_rbeat[2], m_rbeat[1], m_rbeat[0]};
        m_kind = 0;
        m_done = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("read_o", read_o, m_kind == 1);
        chk("write_o", write_o, m_kind == 2);
        chk("resp_o", resp_o, m_done);
        chk("line_o", line_o, m_line);
        chk("rd_wr_exclusive", read_o & write_o, 1'b0);
        if (m_kind != 0) chk("address_o", address_o, m_addr);
        if (m_kind == 2) chk("burst_o", burst_o, m_wbeat[m_beats]);
      end
    end
  end

  localparam logic [255:0] RdLine = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] Rd2Line = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                      64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};

  initial begin
    logic [63:0]  rd_beats[4];
    logic [63:0]  wd[4];
    logic         wr_pat[7];
    int           wr_idx[7];
    logic         rd2_pat[5];
    logic [63:0]  rd2_beats[4];
    int           n;

    rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    wd = '{64'hD0D0_D0D0_D0D0_D0D0, 64'hD1D1_D1D1_D1D1_D1D1,
           64'hD2D2_D2D2_D2D2_D2D2, 64'hD3D3_D3D3_D3D3_D3D3};
    wr_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    wr_idx = '{0, 0, 1, 1, 1, 2, 3};
    rd2_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    rd2_beats = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                  64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};

    rst = 1'b0; read_i = 0; write_i = 0; resp_i = 0;
    line_i = '0; address_i = '0; burst_i = '0;
    #3;
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_address_o", address_o, 32'h0);
    chk("rst_burst_o", burst_o, 64'h0);
    chk("rst_line_o", line_o, 256'h0);
    @(negedge clk);
    rst = 1'b1;

    // Read, no wait states.
    @(negedge clk);
    read_i = 1; address_i = 32'h0000_1234;
    @(negedge clk);
    chk("rd_read_o_c1", read_o, 1'b1);
    chk("rd_address_o", address_o, 32'h0000_1220);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = rd_beats[k];
      @(negedge clk);
      if (k < 3) chk("rd_resp_early", resp_o, 1'b0);
    end
    resp_i = 0; read_i = 0;
    chk("rd_resp_c5", resp_o, 1'b1);
    chk("rd_line", line_o, RdLine);
    @(negedge clk);
    chk("rd_resp_c6", resp_o, 1'b0);

    // Write with wait states; cache inputs scrambled mid-burst.
    write_i = 1; address_i = 32'h0000_ABCD; line_i = {wd[3], wd[2], wd[1], wd[0]};
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      chk("wr_burst_o", burst_o, wd[wr_idx[i]]);
      chk("wr_address_o", address_o, 32'h0000_ABC0);
      resp_i = wr_pat[i];
      if (i == 2) begin address_i = 32'hFFFF_FFE0; line_i = '0; end
      @(negedge clk);
    end
    resp_i = 0;
    chk("wr_resp", resp_o, 1'b1);
    chk("wr_line_kept", line_o, RdLine);
    write_i = 0; address_i = '0;

    // Simultaneous read and write: write wins, one resp.
    @(negedge clk);
    read_i = 1; write_i = 1; address_i = 32'h8000_0047;
    line_i = {4{64'hE1E2_E3E4_E5E6_E7E8}};
    @(negedge clk);
    chk("both_write_o", write_o, 1'b1);
    chk("both_read_o", read_o, 1'b0);
    chk("both_address_o", address_o, 32'h8000_0040);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1;
      @(negedge clk);
    end
    resp_i = 0; read_i = 0; write_i = 0;
    chk("both_resp", resp_o, 1'b1);
    @(negedge clk);
    chk("both_single_resp", resp_o, 1'b0);

    // Reset after two read beats.
    read_i = 1; address_i = 32'h0000_2000;
    @(negedge clk);
    resp_i = 1; burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk);
    burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
    @(negedge clk);
    chk("rst_mid_read_o_before", read_o, 1'b1);
    resp_i = 0; read_i = 0;
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_read_o", read_o, 1'b0);
    chk("rst_mid_resp_o", resp_o, 1'b0);
    chk("rst_mid_line_o", line_o, 256'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    read_i = 1; address_i = 32'h0000_3010;
    @(negedge clk);
    chk("rd2_address_o", address_o, 32'h0000_3000);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      resp_i = rd2_pat[i];
      burst_i = rd2_pat[i] ? rd2_beats[n] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (rd2_pat[i]) n++;
      @(negedge clk);
    end
    resp_i = 0; read_i = 0;
    chk("rd2_resp", resp_o, 1'b1);
    chk("rd2_line", line_o, Rd2Line);

    // Spurious resp_i while idle.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      resp_i = 1;
      @(negedge clk);
      chk("idle_resp_o", resp_o, 1'b0);
      chk("idle_line_o", line_o, Rd2Line);
      chk("idle_read_o", read_o, 1'b0);
    end
    resp_i = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
